// File: rtl/decodificador_servo.sv
// Measures the high time of a 50 Hz servo pulse and decodes it to a 3-bit position code, flagging bad widths and loss of signal.
// Results register on the 4th clock edge counted from the first edge that samples pwm low; the input is never backpressured.
module decodificador_servo #(
  parameter int BASE    = 50000,
  parameter int STEP    = 7143,
  parameter int TIMEOUT = 1250000,
  parameter int CW      = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pwm,
  output logic [2:0] posicao,
  output logic       valido,
  output logic       erro,
  output logic       db_pwm,
  output logic [2:0] db_posicao,
  output logic [1:0] db_estado
);

  localparam int LIM0   = BASE - STEP / 2;
  localparam int LIMMAX = LIM0 + 8 * STEP;

  localparam logic [CW-1:0] UM       = CW'(1);
  localparam logic [CW-1:0] LIM0_C   = CW'(LIM0);
  localparam logic [CW-1:0] LIMMAX_C = CW'(LIMMAX);
  localparam logic [CW-1:0] STEP_C   = CW'(STEP);
  localparam logic [CW-1:0] TMO_C    = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMO_M1   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ESPERA_BAIXO  = 2'b00,
    ESPERA_SUBIDA = 2'b01,
    MEDE          = 2'b10,
    AVALIA        = 2'b11
  } estado_t;

  estado_t       estado;
  logic          s1;
  logic          s;
  logic [1:0]    aquece;
  logic [CW-1:0] largura;
  logic [CW-1:0] largura_prox;
  logic [CW-1:0] passo;
  logic [3:0]    faixa;
  logic          em_faixa;
  logic [CW-1:0] tempo;
  logic          subida;

  assign largura_prox = largura + UM;
  assign subida       = (estado == ESPERA_SUBIDA) && s;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1       <= 1'b0;
      s        <= 1'b0;
      aquece   <= 2'd0;
      estado   <= ESPERA_BAIXO;
      largura  <= '0;
      passo    <= '0;
      faixa    <= 4'd0;
      em_faixa <= 1'b0;
      tempo    <= '0;
      posicao  <= 3'd0;
      valido   <= 1'b0;
      erro     <= 1'b0;
    end else begin
      s1 <= pwm;
      s  <= s1;

      // s only reflects the pin once both synchronizer stages have been refilled after reset.
      if (aquece != 2'd2) aquece <= aquece + 2'd1;

      if (subida) tempo <= '0;
      else if (tempo != TMO_C) tempo <= tempo + UM;

      if (!subida && tempo >= TMO_M1) begin
        valido <= 1'b0;
        erro   <= 1'b1;
      end

      case (estado)
        ESPERA_BAIXO: begin
          if (aquece == 2'd2 && !s) estado <= ESPERA_SUBIDA;
        end
        ESPERA_SUBIDA: begin
          if (s) begin
            largura  <= UM;
            em_faixa <= (LIM0 == 1);
            faixa    <= 4'd0;
            passo    <= UM;
            estado   <= MEDE;
          end
        end
        MEDE: begin
          if (!s) begin
            estado <= AVALIA;
          end else if (largura >= LIMMAX_C) begin
            erro   <= 1'b1;
            valido <= 1'b0;
            estado <= ESPERA_BAIXO;
          end else begin
            largura <= largura_prox;
            // faixa counts whole STEP bins past LIM0; passo counts cycles inside the current bin.
            if (largura_prox == LIM0_C) begin
              em_faixa <= 1'b1;
              faixa    <= 4'd0;
              passo    <= UM;
            end else if (em_faixa) begin
              if (passo == STEP_C) begin
                faixa <= faixa + 4'd1;
                passo <= UM;
              end else begin
                passo <= passo + UM;
              end
            end
          end
        end
        AVALIA: begin
          if (em_faixa && !faixa[3]) begin
            posicao <= faixa[2:0];
            valido  <= 1'b1;
            erro    <= 1'b0;
          end else begin
            valido <= 1'b0;
            erro   <= 1'b1;
          end
          estado <= ESPERA_SUBIDA;
        end
        default: estado <= ESPERA_BAIXO;
      endcase
    end
  end

  assign db_pwm     = s;
  assign db_posicao = posicao;
  assign db_estado  = estado;

endmodule

// File: tb/tb_decodificador_servo.sv
// Directed bench for decodificador_servo with small parameters (LIM0=45, LIMMAX=125, TIMEOUT=500).
module tb_decodificador_servo;

  logic       clock = 1'b0;
  logic       reset;
  logic       pwm;
  logic [2:0] posicao;
  logic       valido;
  logic       erro;
  logic       db_pwm;
  logic [2:0] db_posicao;
  logic [1:0] db_estado;

  typedef struct packed {
    logic [2:0] pos;
    logic       vld;
    logic       err;
  } res_t;

  res_t fila[$];
  res_t atual;
  int   checks   = 0;
  int   failures = 0;

  decodificador_servo #(
    .BASE(50), .STEP(10), .TIMEOUT(500), .CW(10)
  ) dut (
    .clock(clock), .reset(reset), .pwm(pwm),
    .posicao(posicao), .valido(valido), .erro(erro),
    .db_pwm(db_pwm), .db_posicao(db_posicao), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: code k covers [45+10k, 55+10k); anything outside is an error keeping the old code.
  function automatic res_t modelo(input int w, input res_t prev);
    res_t r;
    if (w < 45 || w >= 125) begin
      r.pos = prev.pos;
      r.vld = 1'b0;
      r.err = 1'b1;
    end else begin
      r.pos = 3'((w - 45) / 10);
      r.vld = 1'b1;
      r.err = 1'b0;
    end
    return r;
  endfunction

  // Called at a negedge with pwm low; drives a w-cycle pulse then baixo low cycles.
  task automatic pulso(input int w, input int baixo);
    res_t esp;
    fila.push_back(modelo(w, atual));
    pwm = 1'b1;
    @(negedge clock);
    chk("db_pwm_lag1", 32'(db_pwm), 32'd0);
    @(negedge clock);
    chk("db_pwm_lag2", 32'(db_pwm), 32'd1);
    repeat (w - 2) @(negedge clock);
    chk("estado_mede", 32'(db_estado), 32'd2);
    pwm = 1'b0;
    repeat (3) @(negedge clock);
    chk("estado_avalia", 32'(db_estado), 32'd3);
    chk("latencia_saidas", 32'({posicao, valido, erro}), 32'(atual));
    @(negedge clock);
    esp = fila.pop_front();
    chk("posicao", 32'(posicao), 32'(esp.pos));
    chk("valido", 32'(valido), 32'(esp.vld));
    chk("erro", 32'(erro), 32'(esp.err));
    chk("db_posicao", 32'(db_posicao), 32'(esp.pos));
    chk("estado_pos_avalia", 32'(db_estado), 32'd1);
    atual = esp;
    repeat (baixo) @(negedge clock);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_posicao"}, 32'(posicao), 32'd0);
    chk({tag, "_valido"}, 32'(valido), 32'd0);
    chk({tag, "_erro"}, 32'(erro), 32'd0);
    chk({tag, "_estado"}, 32'(db_estado), 32'd0);
  endtask

  initial begin
    int larguras[6] = '{45, 54, 55, 84, 115, 124};
    pwm   = 1'b0;
    reset = 1'b1;
    atual = '0;
    repeat (3) @(negedge clock);
    chk_reset("reset");
    chk("reset_db_pwm", 32'(db_pwm), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("espera_subida", 32'(db_estado), 32'd1);

    // Nominal position 000, then the threshold edges.
    pulso(50, 150);
    foreach (larguras[i]) pulso(larguras[i], 100);

    // Too short, then a good pulse, then a pulse held high past LIMMAX.
    pulso(44, 100);
    pulso(84, 100);
    pwm = 1'b1;
    repeat (127) @(negedge clock);
    chk("longo_antes_erro", 32'(erro), 32'd0);
    chk("longo_antes_estado", 32'(db_estado), 32'd2);
    @(negedge clock);
    chk("longo_erro", 32'(erro), 32'd1);
    chk("longo_valido", 32'(valido), 32'd0);
    chk("longo_estado", 32'(db_estado), 32'd0);
    chk("longo_posicao", 32'(posicao), 32'd3);
    atual = '{pos: 3'd3, vld: 1'b0, err: 1'b1};
    pwm = 1'b0;
    repeat (20) @(negedge clock);
    chk("longo_retoma", 32'(db_estado), 32'd1);
    pulso(60, 100);

    // Loss of signal: rising edge seen at N+2, timeout lands on edge N+502.
    pulso(50, 0);
    repeat (448) @(negedge clock);
    chk("timeout_antes_valido", 32'(valido), 32'd1);
    chk("timeout_antes_erro", 32'(erro), 32'd0);
    @(negedge clock);
    chk("timeout_valido", 32'(valido), 32'd0);
    chk("timeout_erro", 32'(erro), 32'd1);
    chk("timeout_posicao", 32'(posicao), 32'd0);
    atual = '{pos: 3'd0, vld: 1'b0, err: 1'b1};
    repeat (20) @(negedge clock);
    pulso(70, 100);

    // Reset released mid-pulse: the pulse in progress must be ignored.
    reset = 1'b1;
    pwm   = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset("reset_alto");
    reset = 1'b0;
    repeat (30) @(negedge clock);
    chk("meio_pulso_estado", 32'(db_estado), 32'd0);
    chk("meio_pulso_valido", 32'(valido), 32'd0);
    pwm = 1'b0;
    repeat (10) @(negedge clock);
    chk("meio_pulso_subida", 32'(db_estado), 32'd1);
    atual = '0;
    pulso(70, 100);

    // Reset asserted while measuring.
    pwm = 1'b1;
    repeat (20) @(negedge clock);
    chk("mede_antes_reset", 32'(db_estado), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    chk_reset("reset_mede");
    reset = 1'b0;
    pwm   = 1'b0;
    repeat (5) @(negedge clock);
    chk("fila_vazia", 32'(fila.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
